// File: rtl/quad_pkg.sv
//------------------------------------------------------------------------------
// Module : quad_pkg
// Brief  : Shared types and helpers for the quadrature encoder front end.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package quad_pkg;

    typedef enum logic [1:0] {
        X1 = 2'b00,
        X2 = 2'b01,
        X4 = 2'b10
    } quad_mode_t;

    // Encoding is {A,B}, so the filtered inputs map straight onto a state.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } dec_state_t;

    function automatic int startup_cyc(input int sync_stages, input int filt_len);
        return sync_stages + filt_len + 1;
    endfunction

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 4;
    localparam int STARTUP_CYC     = startup_cyc(SYNC_STAGES_DEF, FILT_LEN_DEF);

    function automatic dec_state_t fwd_next(input dec_state_t s);
        case (s)
            S00:     return S10;
            S10:     return S11;
            S11:     return S01;
            default: return S00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_encoder_decoder_if.sv
//------------------------------------------------------------------------------
// Module : quad_encoder_decoder_if
// Brief  : Encoder inputs, control and status bundle for quad_encoder_decoder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface quad_encoder_decoder_if #(
    parameter int CNT_W = 16
);
    logic             a_in;
    logic             b_in;
    logic [1:0]       mode;
    logic             sat_en;
    logic [CNT_W-1:0] limit;
    logic             clear;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step;
    logic             zero_pulse;
    logic             err;

    modport master (
        output a_in, b_in, mode, sat_en, limit, clear, err_clr,
        input  count, dir, step, zero_pulse, err
    );

    modport slave (
        input  a_in, b_in, mode, sat_en, limit, clear, err_clr,
        output count, dir, step, zero_pulse, err
    );
endinterface

`default_nettype wire

// File: rtl/quad_sync_filter.sv
//------------------------------------------------------------------------------
// Module : quad_sync_filter
// Brief  : Synchroniser chain plus stability-count glitch filter, one input.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quad_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  din,
    output logic dout
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;

    // The FILT_LEN-th consecutive differing sample is the one that commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            if (r_sync[SYNC_STAGES-1] != r_filt) begin
                if (r_cnt == CW'(FILT_LEN - 1)) begin
                    r_filt <= r_sync[SYNC_STAGES-1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_filt;

endmodule

`default_nettype wire

// File: rtl/quad_encoder_decoder.sv
//------------------------------------------------------------------------------
// Module : quad_encoder_decoder
// Brief  : Quadrature decoder with x1/x2/x4 counting, wrap/saturate range.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quad_encoder_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  wire                    clk,
    input  wire                    reset,
    quad_encoder_decoder_if.slave  bus
);
    localparam int START_CYC = startup_cyc(SYNC_STAGES, FILT_LEN);
    localparam int SC_W      = $clog2(START_CYC + 1);

    logic             w_a;
    logic             w_b;
    dec_state_t       r_state;
    dec_state_t       w_next;
    logic [1:0]       w_prev_ab;
    logic [1:0]       w_next_ab;
    logic [SC_W-1:0]  r_start;
    logic             w_armed;
    logic             w_change;
    logic             w_illegal;
    logic             w_fwd;
    logic             w_count_en;
    logic             w_step;
    quad_mode_t       w_mode;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_stepped;
    logic             r_dir;
    logic             r_step;
    logic             r_zero;
    logic             r_err;

    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .din   (bus.a_in),
        .dout  (w_a)
    );

    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .din   (bus.b_in),
        .dout  (w_b)
    );

    always_comb begin
        w_next_ab  = {w_a, w_b};
        w_next     = dec_state_t'(w_next_ab);
        w_prev_ab  = r_state;
        w_armed    = (r_start == SC_W'(START_CYC));
        w_change   = (w_next_ab != w_prev_ab);
        w_illegal  = ((w_prev_ab ^ w_next_ab) == 2'b11);
        w_fwd      = (w_next == fwd_next(r_state));
        w_mode     = (bus.mode == 2'b11) ? X4 : quad_mode_t'(bus.mode);
        w_count_en = 1'b1;
        case (w_mode)
            X1:      w_count_en = ((r_state == S00) && (w_next == S10)) ||
                                  ((r_state == S10) && (w_next == S00));
            X2:      w_count_en = (w_prev_ab[1] != w_next_ab[1]);
            default: w_count_en = 1'b1;
        endcase
        w_step = w_change && !w_illegal && w_armed && w_count_en;

        // Forward saturates/wraps at or above limit so a lowered limit still bounds the count.
        if (w_fwd) begin
            if (r_count >= bus.limit)
                w_stepped = bus.sat_en ? bus.limit : '0;
            else
                w_stepped = r_count + CNT_W'(1);
        end else begin
            if (r_count == '0)
                w_stepped = bus.sat_en ? '0 : bus.limit;
            else
                w_stepped = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S00;
            r_start <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (!w_armed)
                r_start <= r_start + SC_W'(1);
            r_state <= w_next;
            r_step  <= w_step;
            r_zero  <= 1'b0;
            if (w_step)
                r_dir <= w_fwd;
            if (bus.clear) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= w_stepped;
                r_zero  <= (w_stepped == '0) && (r_count != '0);
            end
            if (w_change && w_illegal && w_armed)
                r_err <= 1'b1;
            else if (bus.err_clr)
                r_err <= 1'b0;
        end
    end

    assign bus.count      = r_count;
    assign bus.dir        = r_dir;
    assign bus.step       = r_step;
    assign bus.zero_pulse = r_zero;
    assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_decoder.sv
//------------------------------------------------------------------------------
// Module : tb_quad_encoder_decoder
// Brief  : Self-checking bench against a phase-position reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_quad_encoder_decoder;
    logic clk = 1'b0;
    logic reset;

    quad_encoder_decoder_if #(.CNT_W(8)) bus ();

    quad_encoder_decoder #(.CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Encoder phases in forward order; position index moves +1 forward.
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    int m_count, m_limit, m_mode, m_pos, m_steps, m_zeros;
    bit m_sat, m_err, m_dir;
    int obs_steps = 0;
    int obs_zeros = 0;

    always @(negedge clk) begin
        if (bus.step)       obs_steps++;
        if (bus.zero_pulse) obs_zeros++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input int p);
        logic [1:0] v;
        v = seq[p];
        bus.a_in = v[1];
        bus.b_in = v[0];
    endtask

    task automatic set_ctl();
        bus.mode   = 2'(m_mode);
        bus.limit  = 8'(m_limit);
        bus.sat_en = m_sat;
    endtask

    // delta: +1 forward, -1 reverse, 2 = both channels flip (illegal)
    task automatic model_apply(input int delta);
        int np, oldc;
        logic [1:0] o, n;
        bit counted, fwd;
        np = (m_pos + delta + 4) % 4;
        o = seq[m_pos];
        n = seq[np];
        if (delta == 2) begin
            m_err = 1'b1;
        end else begin
            fwd = (delta == 1);
            if (m_mode == 0)      counted = (m_pos == 0 && np == 1) || (m_pos == 1 && np == 0);
            else if (m_mode == 1) counted = (o[1] != n[1]);
            else                  counted = 1'b1;
            if (counted) begin
                oldc = m_count;
                if (fwd) m_count = (m_count >= m_limit) ? (m_sat ? m_limit : 0) : m_count + 1;
                else     m_count = (m_count == 0) ? (m_sat ? 0 : m_limit) : m_count - 1;
                m_steps++;
                m_dir = fwd;
                if (m_count == 0 && oldc != 0) m_zeros++;
            end
        end
        m_pos = np;
    endtask

    task automatic move(input int delta, input int hold);
        model_apply(delta);
        set_ab(m_pos);
        tick(hold);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        m_count = 0;
        check_eq("clear", bus.count, 0);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_count"}, bus.count, m_count);
        check_eq({tag, "_steps"}, obs_steps, m_steps);
        check_eq({tag, "_zeros"}, obs_zeros, m_zeros);
        check_eq({tag, "_err"},   bus.err,   m_err);
    endtask

    initial begin
        int old, r;
        m_count = 0; m_limit = 255; m_mode = 2; m_pos = 0; m_steps = 0; m_zeros = 0;
        m_sat = 0; m_err = 0; m_dir = 0;
        bus.a_in = 0; bus.b_in = 0; bus.clear = 0; bus.err_clr = 0;
        set_ctl();
        reset = 1'b1;
        tick(3);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_dir",   bus.dir, 0);
        check_eq("rst_step",  bus.step, 0);
        check_eq("rst_zero",  bus.zero_pulse, 0);
        check_eq("rst_err",   bus.err, 0);
        reset = 1'b0;
        tick(20);

        // x4 forward with exact first-edge latency
        old = m_count;
        model_apply(1);
        set_ab(m_pos);
        tick(6);
        check_eq("lat_pre", bus.count, old);
        tick(1);
        check_eq("lat_edge", bus.count, m_count);
        check_eq("lat_step", bus.step, 1);
        tick(3);
        for (int i = 0; i < 11; i++) move(1, 10);
        check_all("x4_fwd");
        check_eq("x4_val", bus.count, 12);
        check_eq("x4_dir", bus.dir, 1);

        do_clear();
        m_mode = 1; set_ctl();
        for (int i = 0; i < 12; i++) move(1, 10);
        check_all("x2_fwd");
        check_eq("x2_val", bus.count, 6);

        do_clear();
        m_mode = 0; set_ctl();
        for (int i = 0; i < 12; i++) move(1, 10);
        check_eq("x1_val", bus.count, 3);
        for (int i = 0; i < 12; i++) move(-1, 10);
        check_all("x1_rev");
        check_eq("x1_dir", bus.dir, 0);

        // glitch: 3-cycle pulse rejected, 4-cycle pulse accepted (00->10->00)
        bus.a_in = 1; tick(3); bus.a_in = 0; tick(12);
        check_all("glitch3");
        bus.a_in = 1; tick(4); bus.a_in = 0; tick(12);
        model_apply(1);
        model_apply(-1);
        check_all("glitch4");

        // range limits
        m_mode = 2; m_limit = 5; m_sat = 0; set_ctl();
        for (int i = 0; i < 5; i++) move(1, 10);
        check_eq("lim_at5", bus.count, 5);
        move(1, 10);
        check_all("lim_wrap_fwd");
        move(-1, 10);
        check_all("lim_wrap_rev");
        m_sat = 1; set_ctl();
        move(1, 10);
        check_all("lim_sat");
        check_eq("lim_sat_val", bus.count, 5);

        // illegal transitions, err_clr colliding with a new illegal one
        move(2, 12);
        check_all("illegal");
        model_apply(2);
        set_ab(m_pos);
        tick(6);
        bus.err_clr = 1;
        tick(1);
        bus.err_clr = 0;
        check_eq("errclr_set_wins", bus.err, 1);
        tick(5);
        bus.err_clr = 1; tick(1); bus.err_clr = 0;
        m_err = 0;
        check_eq("errclr", bus.err, 0);

        // randomized walks
        for (int blk = 0; blk < 6; blk++) begin
            m_mode  = $urandom_range(0, 3);
            m_limit = $urandom_range(3, 40);
            m_sat   = 1'($urandom_range(0, 1));
            set_ctl();
            for (int i = 0; i < 30; i++) begin
                r = $urandom_range(0, 9);
                move((r < 5) ? 1 : (r < 9) ? -1 : 2, $urandom_range(8, 14));
                check_eq("rand_count", bus.count, m_count);
            end
            check_all("rand_blk");
            if (m_steps > 0) check_eq("rand_dir", bus.dir, m_dir);
            bus.err_clr = 1; tick(1); bus.err_clr = 0;
            m_err = 0;
        end

        // reset mid-operation with inputs landing on 11
        m_mode = 2; m_limit = 255; m_sat = 0; set_ctl();
        do_clear();
        for (int i = 0; i < 9; i++) move(1, 10);
        check_eq("pre_rst", bus.count, 9);
        reset = 1'b1;
        m_pos = 2;
        set_ab(m_pos);
        tick(1);
        check_eq("mid_rst_count", bus.count, 0);
        check_eq("mid_rst_dir",   bus.dir, 0);
        check_eq("mid_rst_step",  bus.step, 0);
        check_eq("mid_rst_zero",  bus.zero_pulse, 0);
        check_eq("mid_rst_err",   bus.err, 0);
        tick(2);
        reset = 1'b0;
        m_count = 0; m_err = 0; m_dir = 0;
        tick(20);
        check_all("startup11");

        // clear colliding with a forward step
        model_apply(1);
        m_count = 0;
        set_ab(m_pos);
        tick(6);
        bus.clear = 1;
        tick(1);
        bus.clear = 0;
        check_eq("clr_step_count", bus.count, 0);
        check_eq("clr_step_step",  bus.step, 1);
        check_eq("clr_step_zero",  bus.zero_pulse, 0);
        tick(4);
        check_all("clr_step");
        check_eq("clr_step_dir", bus.dir, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
- Parametrised quadrature encoder front end.
- Per-input path: asynchronous A/B → synchroniser → glitch filter → Gray-code decoder FSM.
- Count behaviour: selectable x1/x2/x4 resolution; wrap or saturate inside a programmable range 0..limit.
- Status outputs: step, direction, zero-crossing pulse and a sticky illegal-transition flag.
- Feeds the painter's position/trigger logic.

Parameters:
- CNT_W, 16, counter width in bits.
- SYNC_STAGES, 2, synchroniser flops per input (≥2).
- FILT_LEN, 4, consecutive stable samples required to accept an input change (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_in  in  1  encoder channel A, asynchronous.
- b_in  in  1  encoder channel B, asynchronous.
- mode  in  2  00 = x1, 01 = x2, 10 = x4, 11 = treated as x4.
- sat_en  in  1  1 = saturate at 0/limit; 0 = wrap.
- limit  in  CNT_W  upper bound of count range.
- clear  in  1  synchronous count clear.
- err_clr  in  1  clears err.
- count  out  CNT_W  position count.
- dir  out  1  direction of last counted step (1 = forward).
- step  out  1  one-cycle pulse per counted step.
- zero_pulse  out  1  one-cycle pulse when count becomes 0 by stepping.
- err  out  1  sticky illegal-transition flag.

Behaviour:
- Reset, sampled on a clk edge, clears on the next edge: count=0, dir=0, step=0, zero_pulse=0, err=0, sync/filter flops=0, decoder state=S00, startup counter=0. Reset mid-operation aborts everything identically.
- Synchroniser: SYNC_STAGES flops per input.
- Filter, per input:
  - A counter increments while the synced value differs from the filtered value; it clears when they match.
  - When the counter reaches FILT_LEN, the filtered value takes the synced value and the counter clears.
  - Pulses shorter than FILT_LEN cycles are never seen.
- Latency: a_in/b_in edge → filtered change = SYNC_STAGES+FILT_LEN cycles. Filtered change → count/step/dir update = 1 cycle.
- Startup: for the first SYNC_STAGES+FILT_LEN+1 cycles after reset deasserts, filtered changes update decoder state only (no count, no err). This absorbs non-00 resting positions.
- Decoder states S00, S10, S11, S01 ({A,B}).
  - Forward: S00→S10→S11→S01→S00.
  - Reverse: the opposite direction.
  - Both bits changing in one cycle is illegal: no count, err←1, state takes the new value.
- Counting rule by mode:
  - x4: every legal transition counts.
  - x2: only transitions where A changes.
  - x1: only S00→S10 (forward) and S10→S00 (reverse).
- Arithmetic, for each counted step (forward = +1, reverse = −1):
  - Forward with count ≥ limit: sat → limit; wrap → 0.
  - Reverse with count = 0: sat → 0; wrap → limit.
  - Otherwise count ±1.
  - step pulses and dir updates even when saturated and held.
- zero_pulse: asserted in the cycle count becomes 0 from non-zero due to a step, including wrap. Not asserted on clear, reset, or when held at 0 by saturation.
- clear: count←0 next cycle; it overrides a same-cycle step. step and dir still reflect that step; zero_pulse is not asserted.
- err_clr and a new illegal transition in the same cycle: set wins.
- limit changes take effect on the next step. count is not retroactively clamped.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package quad_pkg holds:
  - enum quad_mode_t (X1, X2, X4);
  - enum dec_state_t (S00, S10, S11, S01);
  - localparam STARTUP_CYC derived from SYNC_STAGES and FILT_LEN.
- Sub-module quad_sync_filter: one input; SYNC_STAGES and FILT_LEN as parameters; sync chain plus stability counter. Instantiated twice.
- Decoder FSM, counter and flags live in the top module.

Test Plan (CNT_W=8, SYNC_STAGES=2, FILT_LEN=4, limit=255, after startup):
- Forward, x4: 3 full forward cycles, 10 clk per phase → count=12, 12 step pulses, dir=1, err=0. First count change exactly 7 cycles after the first a_in edge.
- Mode compare: same 3 cycles forward in x2 → count=6; in x1 → count=3. Then 3 reverse cycles in x1 → count=0, with zero_pulse in the step-to-0 cycle.
- Glitch: 3-cycle pulse on a_in → no count change, no step. 4-cycle pulse → filtered change occurs.
- Limits: limit=5, sat_en=0, count=5, one forward x4 step → count=0, zero_pulse=1. Then one reverse step → count=5. With sat_en=1 at count=5, forward step → count=5, step=1.
- Illegal transition: a_in and b_in toggled in the same cycle → err=1, count unchanged. err_clr pulsed together with another illegal toggle → err stays 1.
- Reset/clear: reset mid-cycle at count=9 → all outputs 0 next edge; inputs resting at 11 produce no err and no count during startup. clear in the same cycle as a forward step → count=0, step=1, no zero_pulse.
